intc_ls1u: RTL and testbench

- Priority interrupt controller that sequences the KC-LS1u+ core's single INT/IVEC_addr interrupt input from 8 peripheral sources.
- Latches requests, applies enable and edge/level configuration, and picks the highest-priority source.
- Issues a single-cycle INT with the matching vector only when the core can accept it: not in its ISR and not stalled by WAIT.
- Configured and observed by the core through a 4-byte memory-mapped register window on the data bus.

---
 rtl/intc_ls1u.sv | 174 +++++++++++++++++
 tb/tb_intc_ls1u.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intc_ls1u.sv
// intc_ls1u: 8-source priority interrupt controller for the KC-LS1u+ core.
// Latches peripheral requests and picks the lowest-index enabled one.
// Delivers a single-cycle INT with its vector only when the core can take it.
// Configured through a 4-byte register window: PEND, EN, EDGE, STATUS.
module intc_ls1u #(
    parameter logic [23:0] BASE_ADDR = 24'hFFFF00,
    parameter logic [15:0] VEC_HI    = 16'h0001
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [7:0]  i_irq_src,
    input  logic        i_cpu_in_isp,
    input  logic        i_cpu_wait,
    output logic        o_cpu_int,
    output logic [23:0] o_cpu_ivec,
    input  logic [23:0] i_daddr,
    input  logic        i_dread,
    input  logic        i_dwrite,
    input  logic [7:0]  i_wdata,
    output logic [7:0]  o_rdata,
    output logic        o_rsel
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FIRE,
        ST_ISR,
        ST_ISR_RUN,
        ST_GAP
    } state_t;

    state_t      r_state;
    state_t      w_nextState;

    logic [7:0]  r_en;
    logic [7:0]  r_edge;
    logic [7:0]  r_edgeLatch;
    logic [7:0]  r_prev;
    logic [2:0]  r_curId;
    logic [23:0] r_ivec;

    logic        w_hit;
    logic        w_wrPend;
    logic        w_wrEn;
    logic        w_wrEdge;
    logic [7:0]  w_edgeNext;
    logic [7:0]  w_edgeSet;
    logic [7:0]  w_dispClr;
    logic [7:0]  w_clr;
    logic [7:0]  w_pend;
    logic [7:0]  w_eligible;
    logic [2:0]  w_winId;
    logic        w_dispatch;
    logic        w_load;
    logic        w_busy;

    // The window is 4-byte aligned, so only the upper address bits decode it.
    // The bus stays inert while reset is held so reads return 0 then.
    assign w_hit    = (i_daddr[23:2] == BASE_ADDR[23:2]);
    assign o_rsel   = i_rst_n & i_dread & w_hit;
    assign w_wrPend = i_dwrite & w_hit & (i_daddr[1:0] == 2'd0);
    assign w_wrEn   = i_dwrite & w_hit & (i_daddr[1:0] == 2'd1);
    assign w_wrEdge = i_dwrite & w_hit & (i_daddr[1:0] == 2'd2);

    // The edge latch is masked with the mode that will hold after this edge,
    // so flipping a source to level mode drops its stale edge bit.
    assign w_edgeNext = w_wrEdge ? i_wdata : r_edge;
    assign w_edgeSet  = i_irq_src & ~r_prev;
    assign w_dispatch = (r_state == ST_FIRE) & ~i_cpu_wait;
    assign w_dispClr  = w_dispatch ? (8'(1) << r_curId) : 8'h00;
    assign w_clr      = (w_wrPend ? i_wdata : 8'h00) | w_dispClr;

    // Level-mode bits follow the request line directly; edge-mode bits come from the latch.
    assign w_pend     = (r_edgeLatch & r_edge) | (i_irq_src & ~r_edge);
    assign w_eligible = w_pend & r_en;
    assign w_busy     = (r_state != ST_IDLE);
    assign o_cpu_ivec = r_ivec;

    // Lowest-index eligible source wins; scanning downward lets bit 0 override.
    always_comb begin
        w_winId = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_winId = 3'(i);
            end
        end
    end

    // Configuration registers and the edge-detect history.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_en        <= 8'h00;
            r_edge      <= 8'h00;
            r_prev      <= 8'h00;
            r_edgeLatch <= 8'h00;
        end else begin
            r_prev      <= i_irq_src;
            r_edge      <= w_edgeNext;
            if (w_wrEn) begin
                r_en <= i_wdata;
            end
            r_edgeLatch <= ((r_edgeLatch & ~w_clr) | w_edgeSet) & w_edgeNext;
        end
    end

    // Dispatch FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and INT generation; priority is only re-evaluated in IDLE.
    always_comb begin
        w_nextState = r_state;
        o_cpu_int   = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if ((w_eligible != 8'h00) && !i_cpu_in_isp) begin
                    w_nextState = ST_FIRE;
                    w_load      = 1'b1;
                end
            end
            ST_FIRE: begin
                o_cpu_int = ~i_cpu_wait;
                if (!i_cpu_wait) begin
                    w_nextState = ST_ISR;
                end
            end
            ST_ISR: begin
                w_nextState = i_cpu_in_isp ? ST_ISR_RUN : ST_IDLE;
            end
            ST_ISR_RUN: begin
                if (!i_cpu_in_isp) begin
                    w_nextState = ST_GAP;
                end
            end
            ST_GAP: begin
                w_nextState = ST_IDLE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Winner id and vector are captured as the FSM leaves IDLE and held through the ISR.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_curId <= 3'd0;
            r_ivec  <= {VEC_HI, 8'h00};
        end else if (w_load) begin
            r_curId <= w_winId;
            r_ivec  <= {VEC_HI, w_winId, 5'b00000};
        end
    end

    // Combinational register read mux.
    always_comb begin
        o_rdata = 8'h00;
        if (o_rsel) begin
            case (i_daddr[1:0])
                2'd0:    o_rdata = w_pend;
                2'd1:    o_rdata = r_en;
                2'd2:    o_rdata = r_edge;
                default: o_rdata = {w_busy, 4'b0000, r_curId};
            endcase
        end
    end

endmodule

// File: tb/tb_intc_ls1u.sv
// tb_intc_ls1u: directed checks of the intc_ls1u register window and dispatch sequencing.
module tb_intc_ls1u;

   localparam logic [23:0] BASE = 24'hFFFF00;

   logic        clk;
   logic        rstN;
   logic [7:0]  irqSrc;
   logic        cpuInIsp;
   logic        cpuWait;
   logic        cpuInt;
   logic [23:0] cpuIvec;
   logic [23:0] daddr;
   logic        dread;
   logic        dwrite;
   logic [7:0]  wdata;
   logic [7:0]  rdata;
   logic        rsel;

   int nChecks = 0;
   int nFails  = 0;

   typedef struct {
      logic        isWrite;
      logic [23:0] addr;
      logic [7:0]  wdata;
      logic [7:0]  expRdata;
      logic        expRsel;
   } busVec_t;

   busVec_t vecs[15];

   intc_ls1u dut (
      .i_clk        (clk),
      .i_rst_n      (rstN),
      .i_irq_src    (irqSrc),
      .i_cpu_in_isp (cpuInIsp),
      .i_cpu_wait   (cpuWait),
      .o_cpu_int    (cpuInt),
      .o_cpu_ivec   (cpuIvec),
      .i_daddr      (daddr),
      .i_dread      (dread),
      .i_dwrite     (dwrite),
      .i_wdata      (wdata),
      .o_rdata      (rdata),
      .o_rsel       (rsel)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Compare one observed value against its hand-computed expectation.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Drive one bus vector and let the combinational read path settle.
   task automatic applyStimulus(input busVec_t v);
      daddr  = v.addr;
      wdata  = v.wdata;
      dwrite = v.isWrite;
      dread  = ~v.isWrite;
      #1;
   endtask

   // Register write: strobe held across one rising edge.
   task automatic busWrite(input logic [1:0] off, input logic [7:0] d);
      daddr  = BASE + {22'd0, off};
      wdata  = d;
      dwrite = 1'b1;
      tick();
      dwrite = 1'b0;
   endtask

   // Combinational register read compared against an expectation.
   task automatic checkReg(input string name, input logic [1:0] off, input logic [7:0] exp);
      daddr = BASE + {22'd0, off};
      dread = 1'b1;
      #1;
      checkOutput(name, {24'd0, rdata}, {24'd0, exp});
      dread = 1'b0;
   endtask

   initial begin
      // Register window vectors: {isWrite, addr, wdata, expRdata, expRsel}
      vecs[0]  = '{1'b1, BASE + 24'd1, 8'hA5, 8'h00, 1'b0};
      vecs[1]  = '{1'b0, BASE + 24'd1, 8'h00, 8'hA5, 1'b1};
      vecs[2]  = '{1'b1, BASE + 24'd2, 8'h3C, 8'h00, 1'b0};
      vecs[3]  = '{1'b0, BASE + 24'd2, 8'h00, 8'h3C, 1'b1};
      vecs[4]  = '{1'b0, BASE + 24'd0, 8'h00, 8'h00, 1'b1};
      vecs[5]  = '{1'b1, BASE + 24'd3, 8'hFF, 8'h00, 1'b0};
      vecs[6]  = '{1'b0, BASE + 24'd3, 8'h00, 8'h00, 1'b1};
      vecs[7]  = '{1'b0, BASE + 24'd4, 8'h00, 8'h00, 1'b0};
      vecs[8]  = '{1'b0, 24'hFFFEFF,   8'h00, 8'h00, 1'b0};
      vecs[9]  = '{1'b1, BASE + 24'd4, 8'hFF, 8'h00, 1'b0};
      vecs[10] = '{1'b0, BASE + 24'd1, 8'h00, 8'hA5, 1'b1};
      vecs[11] = '{1'b1, BASE + 24'd1, 8'h00, 8'h00, 1'b0};
      vecs[12] = '{1'b1, BASE + 24'd2, 8'h00, 8'h00, 1'b0};
      vecs[13] = '{1'b0, BASE + 24'd1, 8'h00, 8'h00, 1'b1};
      vecs[14] = '{1'b0, BASE + 24'd2, 8'h00, 8'h00, 1'b1};

      rstN     = 1'b0;
      irqSrc   = 8'hFF;
      cpuInIsp = 1'b0;
      cpuWait  = 1'b0;
      daddr    = 24'd0;
      dread    = 1'b0;
      dwrite   = 1'b0;
      wdata    = 8'h00;

      // Reset held with every request asserted.
      tick();
      tick();
      checkOutput("rst_int", {31'd0, cpuInt}, 32'd0);
      checkOutput("rst_ivec", {8'd0, cpuIvec}, 32'h000100);
      checkReg("rst_pend", 2'd0, 8'h00);
      checkReg("rst_en", 2'd1, 8'h00);
      checkReg("rst_edge", 2'd2, 8'h00);
      checkReg("rst_status", 2'd3, 8'h00);
      checkOutput("rst_rsel", {31'd0, rsel}, 32'd0);
      irqSrc = 8'h00;
      tick();
      rstN = 1'b1;
      tick();

      // Table-driven register window checks.
      for (int i = 0; i < 15; i++) begin
         applyStimulus(vecs[i]);
         checkOutput($sformatf("vec%0d_rdata", i), {24'd0, rdata}, {24'd0, vecs[i].expRdata});
         checkOutput($sformatf("vec%0d_rsel", i), {31'd0, rsel}, {31'd0, vecs[i].expRsel});
         if (vecs[i].isWrite) begin
            tick();
         end
         dwrite = 1'b0;
         dread  = 1'b0;
      end

      // Single edge source 3.
      busWrite(2'd1, 8'h08);
      busWrite(2'd2, 8'h08);
      irqSrc = 8'h08;
      tick();
      irqSrc = 8'h00;
      checkReg("edge3_pend_latched", 2'd0, 8'h08);
      checkOutput("edge3_int_idle", {31'd0, cpuInt}, 32'd0);
      tick();
      checkOutput("edge3_int_pulse", {31'd0, cpuInt}, 32'd1);
      checkOutput("edge3_ivec", {8'd0, cpuIvec}, 32'h000160);
      tick();
      checkOutput("edge3_int_after", {31'd0, cpuInt}, 32'd0);
      checkReg("edge3_pend_cleared", 2'd0, 8'h00);
      cpuInIsp = 1'b1;
      checkReg("edge3_status_isr", 2'd3, 8'h83);
      tick();
      checkReg("edge3_status_run", 2'd3, 8'h83);
      tick();
      checkOutput("edge3_int_in_isr", {31'd0, cpuInt}, 32'd0);
      cpuInIsp = 1'b0;
      tick();
      checkReg("edge3_status_gap", 2'd3, 8'h83);
      tick();
      checkReg("edge3_status_idle", 2'd3, 8'h03);

      // Two simultaneous edges: id 1 first, then id 5.
      busWrite(2'd1, 8'hFF);
      busWrite(2'd2, 8'hFF);
      irqSrc = 8'h22;
      tick();
      tick();
      checkOutput("prio_int1", {31'd0, cpuInt}, 32'd1);
      checkOutput("prio_ivec1", {8'd0, cpuIvec}, 32'h000120);
      tick();
      cpuInIsp = 1'b1;
      tick();
      tick();
      cpuInIsp = 1'b0;
      tick();
      checkOutput("prio_int_gap", {31'd0, cpuInt}, 32'd0);
      tick();
      checkOutput("prio_int_idle", {31'd0, cpuInt}, 32'd0);
      tick();
      checkOutput("prio_int2", {31'd0, cpuInt}, 32'd1);
      checkOutput("prio_ivec2", {8'd0, cpuIvec}, 32'h0001A0);
      tick();
      tick();
      checkReg("prio_ignored_status", 2'd3, 8'h05);
      checkReg("prio_pend_empty", 2'd0, 8'h00);
      irqSrc = 8'h00;
      tick();

      // WAIT holds off INT while in FIRE.
      irqSrc = 8'h10;
      tick();
      cpuWait = 1'b1;
      tick();
      checkOutput("wait_int_c1", {31'd0, cpuInt}, 32'd0);
      tick();
      checkOutput("wait_int_c2", {31'd0, cpuInt}, 32'd0);
      tick();
      checkOutput("wait_int_c3", {31'd0, cpuInt}, 32'd0);
      cpuWait = 1'b0;
      #1;
      checkOutput("wait_int_release", {31'd0, cpuInt}, 32'd1);
      checkOutput("wait_ivec", {8'd0, cpuIvec}, 32'h000180);
      tick();
      checkOutput("wait_int_after", {31'd0, cpuInt}, 32'd0);
      tick();
      irqSrc = 8'h00;
      tick();

      // Level source 0 held across RET re-dispatches after the gap.
      busWrite(2'd2, 8'h00);
      busWrite(2'd1, 8'h01);
      irqSrc = 8'h01;
      tick();
      checkOutput("lvl_int1", {31'd0, cpuInt}, 32'd1);
      checkOutput("lvl_ivec", {8'd0, cpuIvec}, 32'h000100);
      tick();
      cpuInIsp = 1'b1;
      tick();
      cpuInIsp = 1'b0;
      checkOutput("lvl_int_ret", {31'd0, cpuInt}, 32'd0);
      tick();
      checkOutput("lvl_int_gap", {31'd0, cpuInt}, 32'd0);
      tick();
      checkOutput("lvl_int_idle", {31'd0, cpuInt}, 32'd0);
      tick();
      checkOutput("lvl_int2", {31'd0, cpuInt}, 32'd1);
      tick();
      cpuInIsp = 1'b1;
      busWrite(2'd0, 8'h01);
      checkReg("lvl_pend_w1c_ignored", 2'd0, 8'h01);
      irqSrc = 8'h00;
      checkReg("lvl_pend_dropped", 2'd0, 8'h00);
      cpuInIsp = 1'b0;
      tick();
      tick();
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput($sformatf("lvl_no_int%0d", i), {31'd0, cpuInt}, 32'd0);
      end

      // W1C against a simultaneous new edge, then a plain W1C.
      busWrite(2'd1, 8'h00);
      busWrite(2'd2, 8'hFF);
      irqSrc = 8'h04;
      tick();
      irqSrc = 8'h00;
      tick();
      checkReg("w1c_pend_set", 2'd0, 8'h04);
      irqSrc = 8'h04;
      busWrite(2'd0, 8'h04);
      checkReg("w1c_set_wins", 2'd0, 8'h04);
      irqSrc = 8'h00;
      busWrite(2'd0, 8'h04);
      checkReg("w1c_plain_clear", 2'd0, 8'h00);

      // Switching a source to level mode drops its latched edge.
      irqSrc = 8'h04;
      tick();
      irqSrc = 8'h00;
      tick();
      checkReg("mode_pend_before", 2'd0, 8'h04);
      busWrite(2'd2, 8'h00);
      busWrite(2'd2, 8'hFF);
      checkReg("mode_pend_discarded", 2'd0, 8'h00);

      // Reset in the middle of a dispatch kills INT immediately.
      busWrite(2'd1, 8'h04);
      irqSrc = 8'h04;
      tick();
      irqSrc = 8'h00;
      tick();
      checkOutput("midrst_int_before", {31'd0, cpuInt}, 32'd1);
      rstN = 1'b0;
      #1;
      checkOutput("midrst_int", {31'd0, cpuInt}, 32'd0);
      checkOutput("midrst_ivec", {8'd0, cpuIvec}, 32'h000100);
      tick();
      rstN = 1'b1;
      tick();
      checkOutput("midrst_int_after", {31'd0, cpuInt}, 32'd0);
      checkReg("midrst_en", 2'd1, 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
